// File: rtl/mem_access_if.sv
// mem_access_if: request/response handshake between execute stage (master) and mem_access_unit (slave).
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a synchronous-read word memory.
// Define MEM_ACC_STATS_EN to build saturating load/store/error counters.
module mem_access_unit #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_if.slave        bus,
    output logic               mem_write_enable,
    output logic [31:0]        mem_write_address,
    output logic [31:0]        mem_read_address,
    output logic [31:0]        mem_data_in,
    input  logic [31:0]        mem_data_out,
    output logic [15:0]        stat_loads,
    output logic [15:0]        stat_stores,
    output logic [15:0]        stat_errors
);
    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ERR} state_t;
    localparam logic [31:0] DEPTH_L = DEPTH;
    state_t      state;
    logic        bad_addr;
    logic [31:0] idx;
    assign bad_addr     = (bus.req_addr[1:0] != 2'b00) || ({2'b00, bus.req_addr[31:2]} >= DEPTH_L);
    assign idx          = 32'(bus.req_addr[ADDR_W+1:2]);
    assign bus.req_ready = state == IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_read_address  <= '0;
            mem_data_in       <= '0;
            bus.resp_valid    <= 1'b0;
            bus.resp_rdata    <= '0;
            bus.resp_error    <= 1'b0;
        end else begin
            bus.resp_valid   <= 1'b0;
            mem_write_enable <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    if (bad_addr) state <= ERR;
                    else if (bus.req_write) begin
                        state             <= WR;
                        mem_write_enable  <= 1'b1;
                        mem_write_address <= idx;
                        mem_data_in       <= bus.req_wdata;
                    end else begin
                        state            <= RD1;
                        mem_read_address <= idx;
                    end
                end
                WR: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b1;
                    bus.resp_error <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                RD1: state <= RD2;
                RD2: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b1;
                    bus.resp_error <= 1'b0;
                    bus.resp_rdata <= mem_data_out;
                end
                ERR: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b1;
                    bus.resp_error <= 1'b1;
                    bus.resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef MEM_ACC_STATS_EN
    // each counter bumps on the edge that raises its response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else begin
            if (state == RD2) stat_loads  <= stat_loads  + 16'(stat_loads  != 16'hFFFF);
            if (state == WR)  stat_stores <= stat_stores + 16'(stat_stores != 16'hFFFF);
            if (state == ERR) stat_errors <= stat_errors + 16'(stat_errors != 16'hFFFF);
        end
    end
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errors = '0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit with a behavioural synchronous-read memory.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write_enable;
    logic [31:0] mem_write_address, mem_read_address, mem_data_in, mem_data_out;
    logic [15:0] stat_loads, stat_stores, stat_errors;
    logic [31:0] mem [1024];
    logic        loading = 1'b1;
    int          total = 0, bad = 0, we_cnt = 0, resp_cnt = 0, lat = 0, n = 0;
    logic [31:0] we_addr = '0;

    mem_access_if bus ();

    mem_access_unit #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .mem_write_enable(mem_write_enable),
        .mem_write_address(mem_write_address),
        .mem_read_address(mem_read_address),
        .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out),
        .stat_loads(stat_loads),
        .stat_stores(stat_stores),
        .stat_errors(stat_errors)
    );

    always #5 clk = ~clk;

    // memory preloaded with 0xA5000000 | index while loading is high
    always @(posedge clk) begin
        if (loading) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (mem_write_enable) mem[mem_write_address[9:0]] <= mem_data_in;
        mem_data_out <= mem[mem_read_address[9:0]];
    end

    always @(negedge clk) begin
        if (mem_write_enable) begin
            we_cnt++;
            we_addr = mem_write_address;
        end
        if (bus.resp_valid) resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // issue one request, return cycles from accept edge until resp_valid is seen
    task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, output int l);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        l = 0;
        while (!bus.resp_valid && l < 10) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        loading = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_error", bus.resp_error, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_we", mem_write_enable, 0);
        check("rst_waddr", mem_write_address, 0);
        check("rst_raddr", mem_read_address, 0);
        check("rst_din", mem_data_in, 0);

        req(1'b1, 32'h34, 32'hDEAD_BEEF, lat);
        check("st_lat", lat, 1);
        check("st_err", bus.resp_error, 0);
        check("st_rdata", bus.resp_rdata, 0);
        check("st_we_cnt", we_cnt, 1);
        check("st_waddr", we_addr, 13);
        check("st_mem", mem[13], 32'hDEAD_BEEF);

        req(1'b0, 32'h34, 32'h0, lat);
        check("ld_lat", lat, 2);
        check("ld_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
        check("ld_err", bus.resp_error, 0);

        req(1'b0, 32'h36, 32'h0, lat);
        check("mis_lat", lat, 1);
        check("mis_err", bus.resp_error, 1);
        check("mis_rdata", bus.resp_rdata, 0);
        check("mis_we_cnt", we_cnt, 1);

        req(1'b1, 32'h1000, 32'h1234_5678, lat);
        check("oor_lat", lat, 1);
        check("oor_err", bus.resp_error, 1);
        check("oor_we_cnt", we_cnt, 1);
        req(1'b0, 32'h0, 32'h0, lat);
        check("ld0_lat", lat, 2);
        check("ld0_rdata", bus.resp_rdata, 32'hA500_0000);
        check("ld0_err", bus.resp_error, 0);

        // request changes while the unit is busy; only the accepted one may act
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h44;
        bus.req_wdata = 32'h22;
        @(posedge clk);
        #1;
        n = resp_cnt;
        bus.req_addr  = 32'h48;
        bus.req_wdata = 32'h99;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_resp_cnt", resp_cnt, n + 1);
        check("busy_we_cnt", we_cnt, 2);
        check("busy_waddr", we_addr, 17);
        check("busy_mem17", mem[17], 32'h22);
        check("busy_mem18", mem[18], 32'hA500_0012);

        // reset pulse while the load sits in RD1
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h34;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = resp_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_rd1_resp_cnt", resp_cnt, n);
        check("rst_rd1_ready", bus.req_ready, 1);
        check("rst_rd1_resp_valid", bus.resp_valid, 0);

        req(1'b1, 32'h100, 32'hAAAA_0001, lat);
        check("s1_lat", lat, 1);
        req(1'b1, 32'h104, 32'hBBBB_0002, lat);
        check("s2_lat", lat, 1);
        req(1'b0, 32'h100, 32'h0, lat);
        check("l1_rdata", bus.resp_rdata, 32'hAAAA_0001);
        req(1'b0, 32'h104, 32'h0, lat);
        check("l2_rdata", bus.resp_rdata, 32'hBBBB_0002);
        req(1'b0, 32'h34, 32'h0, lat);
        check("l3_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
        req(1'b0, 32'h101, 32'h0, lat);
        check("e1_err", bus.resp_error, 1);
        @(negedge clk);
`ifdef MEM_ACC_STATS_EN
        check("stat_stores", stat_stores, 2);
        check("stat_loads", stat_loads, 3);
        check("stat_errors", stat_errors, 1);
`else
        check("stat_stores", stat_stores, 0);
        check("stat_loads", stat_loads, 0);
        check("stat_errors", stat_errors, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
